apb_req_master: RTL

APB requester that converts a simple valid/ready command port into a compliant two-phase APB transfer for the timer's slave port (`tim_p*`). Sits directly upstream of the timer: a CPU-side or scripted command source issues single read/write requests. The block runs SETUP/ACCESS sequencing, wait-state handling and error capture, and returns a one-cycle response pulse. It is the synthesizable replacement for the hand-written bus tasks used in simulation.

---
 rtl/apb_req_master_if.sv | 52 +++++
 rtl/apb_req_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/apb_req_master_if.sv
// ============================================================================
//  Module   : apb_req_master_if
//  Brief    : Command/response port and APB requester bus of apb_req_master.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_req_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_strb;

  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  tim_psel;
  logic                  tim_penable;
  logic                  tim_pwrite;
  logic [ADDR_W-1:0]     tim_paddr;
  logic [DATA_W-1:0]     tim_pwdata;
  logic [DATA_W/8-1:0]   tim_pstrb;
  logic [DATA_W-1:0]     tim_prdata;
  logic                  tim_pready;
  logic                  tim_pslverr;

  // The requester's view: it owns req_ready, the response and the APB controls.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_prdata, tim_pready, tim_pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_prdata, tim_pready, tim_pslverr
  );
endinterface

`default_nettype wire

// File: rtl/apb_req_master.sv
// ============================================================================
//  Module   : apb_req_master
//  Brief    : Valid/ready command port to two-phase APB requester with
//             wait-state handling, error capture and one-cycle response pulse.
//             Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_req_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  wire logic         sys_clk,
  input  wire logic         sys_rst_n,
  apb_req_master_if.master  bus
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                timeout_hit;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_err
    $error("apb_req_master: TIMEOUT must lie in 1..255");
  end

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] C_TIMEOUT_M1 = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q;

  // Counts completed wait cycles of the current ACCESS phase.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_ACCESS && !bus.tim_pready) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  assign timeout_hit = (state_q == S_ACCESS) && !bus.tim_pready &&
                       (wait_cnt_q == C_TIMEOUT_M1);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Outputs are computed for the state being entered, so every port is a flop.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = 1'b0;
    psel_d        = 1'b0;
    penable_d     = 1'b0;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_ready_q && bus.req_valid) begin
          state_d  = S_SETUP;
          psel_d   = 1'b1;
          pwrite_d = bus.req_write;
          paddr_d  = bus.req_addr;
          pwdata_d = bus.req_wdata;
          pstrb_d  = bus.req_write ? bus.req_strb : '0;
        end else begin
          req_ready_d = 1'b1;
        end
      end

      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end

      S_ACCESS: begin
        if (bus.tim_pready) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.tim_prdata;
          rsp_err_d   = bus.tim_pslverr;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          pstrb_d     = '0;
        end else if (timeout_hit) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          pwrite_d      = 1'b0;
          paddr_d       = '0;
          pwdata_d      = '0;
          pstrb_d       = '0;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.tim_psel    = psel_q;
  assign bus.tim_penable = penable_q;
  assign bus.tim_pwrite  = pwrite_q;
  assign bus.tim_paddr   = paddr_q;
  assign bus.tim_pwdata  = pwdata_q;
  assign bus.tim_pstrb   = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

`default_nettype wire
